ysyx_25030085_mem_arbiter: RTL and testbench

shares one memory port between instruction fetch (IFU) and load/store (LSU); one outstanding transaction.

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the cycles allowed in RESP before an error response is forced; 0 SHALL disable the timeout.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_addr in 32: IFU read request handshake and word address.
REQ-005 ifu_resp_valid out 1 / ifu_resp_ready in 1 / ifu_rdata out 32 / ifu_resp_err out 1: IFU response channel.
REQ-006 lsu_req_valid in 1 / lsu_req_ready out 1 / lsu_addr in 32 / lsu_wen in 1 / lsu_wdata in 32 / lsu_wmask in 4: LSU request channel; wen=1 is a store.
REQ-007 lsu_resp_valid out 1 / lsu_resp_ready in 1 / lsu_rdata out 32 / lsu_resp_err out 1: LSU response channel.
REQ-008 mem_req_valid out 1 / mem_req_ready in 1 / mem_addr out 32 / mem_wen out 1 / mem_wdata out 32 / mem_wmask out 4: downstream request.
REQ-009 mem_resp_valid in 1 / mem_resp_ready out 1 / mem_rdata in 32 / mem_resp_err in 1: downstream response.

Function
REQ-010 FSM states SHALL be IDLE, REQ, RESP, RET; all handshakes complete when valid and ready are both high on a rising edge.
REQ-011 In IDLE, req_ready SHALL be high combinationally only for the selected requester, and only while it has req_valid high; all other ready outputs low.
REQ-012 Selection: only one valid -> that one; both valid -> the one not granted last (round-robin); last_grant resets to LSU, so the first tie goes to IFU.
REQ-013 On acceptance, addr/wen/wdata/wmask SHALL be latched (IFU: wen=0, wmask=4'hF, wdata=0), grant owner recorded, last_grant updated, IDLE -> REQ.
REQ-014 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready -> RESP; earliest mem_req_valid is the cycle after acceptance.
REQ-015 RESP: mem_resp_ready=1; on mem_resp_valid, latch mem_rdata/mem_resp_err -> RET.
REQ-016 Timeout: counter cleared on RESP entry and incremented each RESP cycle; when TIMEOUT_CYC!=0 and count reaches TIMEOUT_CYC without mem_resp_valid -> RET with rdata=0, err=1.
REQ-017 A mem_resp_valid in the same cycle as the timeout SHALL win (normal response).
REQ-018 RET: owner's resp_valid=1 with latched rdata/err stable; other requester's resp_valid=0; on owner resp_ready -> IDLE.
REQ-019 No new request SHALL be accepted outside IDLE; the earliest back-to-back acceptance is the cycle after RET completes (IDLE one cycle minimum).
REQ-020 mem_resp_ready SHALL be low outside RESP; downstream returns exactly one response per accepted request.
REQ-021 Stores SHALL return a response; rdata is passed through unmodified (mem_rdata).
REQ-022 Requester changing req_valid/fields while not accepted SHALL have no effect on latched state.

Reset
REQ-023 On rst high, immediately and asynchronously: state=IDLE, last_grant=LSU, timeout counter=0, latched addr/wdata/rdata=0, wmask=0, wen=0, err=0.
REQ-024 During and after reset all valid/ready outputs SHALL be 0, except req_ready per REQ-011 once rst deasserts.
REQ-025 Reset mid-transaction SHALL abandon it with no response issued to either requester.

Verification
REQ-026 IFU read addr 0x80000000, mem ready immediately, response 0x00000413 after 2 cycles -> mem_addr=0x80000000, wen=0, wmask=F; ifu_rdata=0x00000413, err=0; lsu_resp_valid never high.
REQ-027 IFU and LSU valid together from reset, both held valid -> grant order IFU, LSU, IFU, LSU over four transactions.
REQ-028 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011, mem_req_ready delayed 3 cycles -> fields stable through REQ; lsu_resp_valid after mem response; err=0.
REQ-029 TIMEOUT_CYC=4, mem never responds -> exactly 4 RESP cycles, then lsu_resp_valid with rdata=0, err=1; TIMEOUT_CYC=0 -> waits indefinitely.
REQ-030 Assert rst while in RESP -> outputs 0 without waiting for a clock edge; after release, state

---
 rtl/ysyx_25030085_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_25030085_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030085_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25030085_mem_arbiter
// Shares a single memory port between instruction fetch (IFU) and load/store
// (LSU). Only one transaction is in flight at a time. It goes through
// IDLE -> REQ -> RESP -> RET. Ties are broken round-robin. A response timeout
// forces an error return if the memory never answers.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   ifu_req_*         : IFU read request (valid/ready, addr)
//   ifu_resp_*        : IFU response (valid/ready, rdata, err)
//   lsu_req_*         : LSU request (valid/ready, addr, wen, wdata, wmask)
//   lsu_resp_*        : LSU response (valid/ready, rdata, err)
//   mem_req_*         : downstream request (valid/ready, addr, wen, wdata, wmask)
//   mem_resp_*        : downstream response (valid/ready, rdata, err)
// Parameter
//   TIMEOUT_CYC       : RESP cycles allowed before an error is forced (0 = never)
// ---------------------------------------------------------------------------
module ysyx_25030085_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        RET  = 2'd3
    } state_t;

    localparam logic        GNT_IFU  = 1'b0;
    localparam logic        GNT_LSU  = 1'b1;
    localparam logic        TMO_EN   = (TIMEOUT_CYC != 32'd0);
    // Timeout fires on the last allowed RESP cycle, i.e. when the count of
    // RESP cycles already spent equals TIMEOUT_CYC-1.
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

    state_t      state_r;
    logic        last_grant_r;
    logic        owner_r;
    logic [31:0] tmo_cnt_r;
    logic [31:0] addr_r;
    logic        wen_r;
    logic [31:0] wdata_r;
    logic [3:0]  wmask_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        sel_lsu_s;
    logic        ifu_ready_s;
    logic        lsu_ready_s;
    logic        tmo_hit_s;
    logic        ret_done_s;

    // Requester selection and IDLE-only request readiness (held low while in reset)
    always_comb begin
        sel_lsu_s   = 1'b0;
        ifu_ready_s = 1'b0;
        lsu_ready_s = 1'b0;
        if (lsu_req_valid && (!ifu_req_valid || (last_grant_r == GNT_IFU))) begin
            sel_lsu_s = 1'b1;
        end else begin
            sel_lsu_s = 1'b0;
        end
        if (!rst && (state_r == IDLE)) begin
            ifu_ready_s = ifu_req_valid && !sel_lsu_s;
            lsu_ready_s = sel_lsu_s;
        end else begin
            ifu_ready_s = 1'b0;
            lsu_ready_s = 1'b0;
        end
    end

    // Timeout detection and RET handshake completion for the current owner
    always_comb begin
        tmo_hit_s  = TMO_EN && (tmo_cnt_r == TMO_LAST);
        ret_done_s = 1'b0;
        if (owner_r == GNT_IFU) begin
            ret_done_s = ifu_resp_ready;
        end else begin
            ret_done_s = lsu_resp_ready;
        end
    end

    // Transaction FSM with latched request/response fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GNT_LSU;
            owner_r      <= GNT_IFU;
            tmo_cnt_r    <= 32'd0;
            addr_r       <= 32'd0;
            wen_r        <= 1'b0;
            wdata_r      <= 32'd0;
            wmask_r      <= 4'd0;
            rdata_r      <= 32'd0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ifu_ready_s) begin
                        addr_r       <= ifu_addr;
                        wen_r        <= 1'b0;
                        wdata_r      <= 32'd0;
                        wmask_r      <= 4'hF;
                        owner_r      <= GNT_IFU;
                        last_grant_r <= GNT_IFU;
                        state_r      <= REQ;
                    end else if (lsu_ready_s) begin
                        addr_r       <= lsu_addr;
                        wen_r        <= lsu_wen;
                        wdata_r      <= lsu_wdata;
                        wmask_r      <= lsu_wmask;
                        owner_r      <= GNT_LSU;
                        last_grant_r <= GNT_LSU;
                        state_r      <= REQ;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        tmo_cnt_r <= 32'd0;
                        state_r   <= RESP;
                    end else begin
                        state_r   <= REQ;
                    end
                end
                RESP: begin
                    tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    // A real response beats a timeout landing in the same cycle.
                    if (mem_resp_valid) begin
                        rdata_r <= mem_rdata;
                        err_r   <= mem_resp_err;
                        state_r <= RET;
                    end else if (tmo_hit_s) begin
                        rdata_r <= 32'd0;
                        err_r   <= 1'b1;
                        state_r <= RET;
                    end else begin
                        state_r <= RESP;
                    end
                end
                RET: begin
                    if (ret_done_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RET;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ifu_req_ready  = ifu_ready_s;
    assign lsu_req_ready  = lsu_ready_s;
    assign mem_req_valid  = (state_r == REQ);
    assign mem_resp_ready = (state_r == RESP);
    assign mem_addr       = addr_r;
    assign mem_wen        = wen_r;
    assign mem_wdata      = wdata_r;
    assign mem_wmask      = wmask_r;
    assign ifu_resp_valid = (state_r == RET) && (owner_r == GNT_IFU);
    assign lsu_resp_valid = (state_r == RET) && (owner_r == GNT_LSU);
    assign ifu_rdata      = rdata_r;
    assign lsu_rdata      = rdata_r;
    assign ifu_resp_err   = err_r;
    assign lsu_resp_err   = err_r;

endmodule

// File: tb/tb_ysyx_25030085_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for ysyx_25030085_mem_arbiter.
// dut uses TIMEOUT_CYC=4; dut0 shares all inputs and uses TIMEOUT_CYC=0.
// ---------------------------------------------------------------------------
module tb_ysyx_25030085_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_resp_ready = 1'b0;
    logic [31:0] ifu_addr = 32'd0;
    logic        lsu_req_valid = 1'b0, lsu_wen = 1'b0, lsu_resp_ready = 1'b0;
    logic [31:0] lsu_addr = 32'd0, lsu_wdata = 32'd0;
    logic [3:0]  lsu_wmask = 4'd0;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_ready, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_wen, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    logic        z_ifu_req_ready, z_ifu_resp_valid, z_ifu_resp_err;
    logic [31:0] z_ifu_rdata;
    logic        z_lsu_req_ready, z_lsu_resp_valid, z_lsu_resp_err;
    logic [31:0] z_lsu_rdata;
    logic        z_mem_req_valid, z_mem_wen, z_mem_resp_ready;
    logic [31:0] z_mem_addr, z_mem_wdata;
    logic [3:0]  z_mem_wmask;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_25030085_mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    ysyx_25030085_mem_arbiter #(.TIMEOUT_CYC(0)) dut0 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(z_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(z_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(z_ifu_rdata), .ifu_resp_err(z_ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(z_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(z_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(z_lsu_rdata), .lsu_resp_err(z_lsu_resp_err),
        .mem_req_valid(z_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(z_mem_addr),
        .mem_wen(z_mem_wen), .mem_wdata(z_mem_wdata), .mem_wmask(z_mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(z_mem_resp_ready),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #12;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_handshakes: got %b want 000000",
                {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_rdata, ifu_resp_err, lsu_resp_err} !== 103'd0) begin
            n_fail++; $display("FAIL reset_fields: addr %h wdata %h wmask %h wen %b rdata %h want all zero",
                mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_rdata);
        end
        n_cmp++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        // First tie after reset goes to IFU.
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL reset_first_tie: got %b want 10", {ifu_req_ready, lsu_req_ready});
        end
        n_cmp++;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_ifu_read();
        ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
        #1;
        if (ifu_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ifu_accept: ready got %b want 1", ifu_req_ready);
        end
        n_cmp++;
        tick();
        ifu_req_valid = 1'b0; ifu_addr = 32'h1234_5678;
        #1;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata} !== {1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'd0}) begin
            n_fail++; $display("FAIL ifu_mem_req: valid %b addr %h wen %b wmask %h wdata %h want 1 80000000 0 f 00000000",
                mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata);
        end
        n_cmp++;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick(); tick();
        if ({mem_resp_ready, mem_req_valid} !== 2'b10) begin
            n_fail++; $display("FAIL ifu_resp_wait: got %b want 10", {mem_resp_ready, mem_req_valid});
        end
        n_cmp++;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413; mem_resp_err = 1'b0;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = 32'd0;
        #1;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata, ifu_resp_err, mem_resp_ready} !== {1'b1, 1'b0, 32'h0000_0413, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL ifu_ret: ifu_v %b lsu_v %b rdata %h err %b want 1 0 00000413 0",
                ifu_resp_valid, lsu_resp_valid, ifu_rdata, ifu_resp_err);
        end
        n_cmp++;
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL ifu_done: got %b want 00", {ifu_resp_valid, lsu_resp_valid});
        end
        n_cmp++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_addr;
        do_reset();
        ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
        lsu_wdata = 32'd0; lsu_wmask = 4'hF;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr = (i % 2 == 0) ? 32'h8000_0100 : 32'h8000_0200;
            if ({ifu_req_ready, lsu_req_ready} !== exp_rdy) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, {ifu_req_ready, lsu_req_ready}, exp_rdy);
            end
            n_cmp++;
            tick();
            if ({mem_addr, ifu_req_ready, lsu_req_ready} !== {exp_addr, 2'b00}) begin
                n_fail++; $display("FAIL rr_req%0d: addr %h readies %b want %h 00", i, mem_addr,
                    {ifu_req_ready, lsu_req_ready}, exp_addr);
            end
            n_cmp++;
            mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
            mem_resp_valid = 1'b1; mem_rdata = 32'(i); tick(); mem_resp_valid = 1'b0;
            if ({ifu_resp_valid, lsu_resp_valid} !== exp_rdy) begin
                n_fail++; $display("FAIL rr_ret%0d: got %b want %b", i, {ifu_resp_valid, lsu_resp_valid}, exp_rdy);
            end
            n_cmp++;
            ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
            tick();
            ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
            #1;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_store();
        lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; lsu_wen = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL st_accept: got %b want 10", {lsu_req_ready, ifu_req_ready});
        end
        n_cmp++;
        tick();
        // Garbage on the unaccepted channel must not disturb the latched request.
        lsu_req_valid = 1'b0; lsu_addr = 32'h0BAD_0BAD; lsu_wdata = 32'h0; lsu_wmask = 4'hC; lsu_wen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if ({mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF}) begin
                n_fail++; $display("FAIL st_hold%0d: v %b wen %b wmask %b addr %h wdata %h want 1 1 0011 80001000 deadbeef",
                    c, mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata);
            end
            n_cmp++;
            tick();
        end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; mem_resp_err = 1'b0; tick(); mem_resp_valid = 1'b0;
        if ({lsu_resp_valid, ifu_resp_valid, lsu_rdata, lsu_resp_err} !== {2'b10, 32'h1234_5678, 1'b0}) begin
            n_fail++; $display("FAIL st_ret: lsu_v %b ifu_v %b rdata %h err %b want 1 0 12345678 0",
                lsu_resp_valid, ifu_resp_valid, lsu_rdata, lsu_resp_err);
        end
        n_cmp++;
        lsu_resp_ready = 1'b1; tick(); lsu_resp_ready = 1'b0;
    endtask

    task automatic test_ret_stall();
        ifu_addr = 32'h8000_0040; ifu_req_valid = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; mem_resp_err = 1'b1; tick();
        mem_resp_valid = 1'b0; mem_rdata = 32'd0; mem_resp_err = 1'b0;
        lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ({ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_req_ready, mem_req_valid} !== {1'b1, 32'hCAFE_F00D, 1'b1, 2'b00}) begin
                n_fail++; $display("FAIL stall%0d: v %b rdata %h err %b lsu_rdy %b want 1 cafef00d 1 0",
                    c, ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_req_ready);
            end
            n_cmp++;
            tick();
        end
        ifu_resp_ready = 1'b1; tick(); ifu_resp_ready = 1'b0;
        if ({lsu_req_ready, ifu_resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL stall_release: got %b want 10", {lsu_req_ready, ifu_resp_valid});
        end
        n_cmp++;
        lsu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        cnt = 0;
        while (mem_resp_ready === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        if (cnt !== 4) begin
            n_fail++; $display("FAIL tmo_cycles: got %0d want 4", cnt);
        end
        n_cmp++;
        if ({lsu_resp_valid, lsu_rdata, lsu_resp_err} !== {1'b1, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL tmo_resp: v %b rdata %h err %b want 1 00000000 1",
                lsu_resp_valid, lsu_rdata, lsu_resp_err);
        end
        n_cmp++;
        for (int c = 0; c < 10; c++) tick();
        if ({z_mem_resp_ready, z_lsu_resp_valid, z_ifu_resp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL tmo_disabled: got %b want 100",
                {z_mem_resp_ready, z_lsu_resp_valid, z_ifu_resp_valid});
        end
        n_cmp++;
        lsu_resp_ready = 1'b1; tick(); lsu_resp_ready = 1'b0;
        // Response arriving on the very cycle the timeout would fire wins.
        lsu_req_valid = 1'b1;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        tick(); tick(); tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_00A5; mem_resp_err = 1'b0;
        tick();
        mem_resp_valid = 1'b0;
        if ({lsu_resp_valid, lsu_rdata, lsu_resp_err} !== {1'b1, 32'h0000_00A5, 1'b0}) begin
            n_fail++; $display("FAIL tmo_tie: v %b rdata %h err %b want 1 000000a5 0",
                lsu_resp_valid, lsu_rdata, lsu_resp_err);
        end
        n_cmp++;
        lsu_resp_ready = 1'b1; tick(); lsu_resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ifu_addr = 32'h8000_0080; ifu_req_valid = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        if ({mem_resp_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_addr} !== {4'b0000, 32'd0}) begin
            n_fail++; $display("FAIL async_reset: flags %b addr %h want 0000 00000000",
                {mem_resp_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, mem_addr);
        end
        n_cmp++;
        mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_resp_valid = 1'b0;
        rst = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0300;
        #1;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL post_reset_tie: got %b want 1000",
                {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
        end
        n_cmp++;
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        if ({mem_req_valid, mem_addr, ifu_resp_valid, lsu_resp_valid} !== {1'b1, 32'h8000_0080, 2'b00}) begin
            n_fail++; $display("FAIL post_reset_req: v %b addr %h resp %b want 1 80000080 00",
                mem_req_valid, mem_addr, {ifu_resp_valid, lsu_resp_valid});
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_round_robin();
        test_store();
        test_ret_stall();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
